// File: rtl/rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl
//   Initiator side of the register-file interface in the multicycle CPU.
//   Operand fetch: accepts a request (rs1/rs2), performs a one-cycle read of
//   the register file, and holds the captured pair on a valid/ready handshake
//   to the execute stage.
//   Writeback: every accepted result becomes a one-cycle write-enable pulse
//   in the following cycle. Consecutive accepts give consecutive pulses.
//   A write pulse that coincides with the read cycle is forwarded to the
//   operand capture when FWD_EN=1.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   issue_valid/ready         fetch request handshake
//   issue_rs1, issue_rs2      source register addresses
//   opnd_valid/ready          operand handshake to the consumer
//   opnd_a, opnd_b            captured operands
//   wb_valid/ready            writeback handshake (never backpressured)
//   wb_addr, wb_data          writeback destination and value
//   rf_mem_en                 register-file read enable (READ state only)
//   rf_read_addr1/2           register-file read addresses
//   rf_read_data1/2           register-file read data (combinational)
//   rf_writ_en/addr/data      register-file write port
//   busy                      read FSM active or write pulse in flight
// ---------------------------------------------------------------------------
module rf_access_ctrl #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [AW-1:0] issue_rs1,
    input  logic [AW-1:0] issue_rs2,
    output logic          opnd_valid,
    input  logic          opnd_ready,
    output logic [DW-1:0] opnd_a,
    output logic [DW-1:0] opnd_b,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          rf_mem_en,
    output logic [AW-1:0] rf_read_addr1,
    output logic [AW-1:0] rf_read_addr2,
    input  logic [DW-1:0] rf_read_data1,
    input  logic [DW-1:0] rf_read_data2,
    output logic          rf_writ_en,
    output logic [AW-1:0] rf_writ_addr,
    output logic [DW-1:0] rf_writ_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg;

    // A new request may be taken from IDLE, or from HOLD in the same cycle
    // the consumer takes the current pair (keeps 2-cycle throughput).
    logic issue_accept;
    assign issue_ready  = (state_reg == IDLE) || ((state_reg == HOLD) && opnd_ready);
    assign issue_accept = issue_valid && issue_ready;

    // -----------------------------------------------------------------------
    // Per-port operand source select: forwarded write data or raw RF data.
    // Only the write pulse already on the RF write port (i.e. accepted one
    // cycle earlier) is considered; a wb accept during READ lands later.
    // -----------------------------------------------------------------------
    logic [AW-1:0] rd_addr    [2];
    logic [DW-1:0] rd_data    [2];
    logic [DW-1:0] capture_val[2];

    assign rd_addr[0] = rf_read_addr1;
    assign rd_addr[1] = rf_read_addr2;
    assign rd_data[0] = rf_read_data1;
    assign rd_data[1] = rf_read_data2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic fwd_hit;
            assign fwd_hit         = FWD_EN && rf_writ_en && (rf_writ_addr == rd_addr[gi]);
            assign capture_val[gi] = fwd_hit ? rf_writ_data : rd_data[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            opnd_valid    <= 1'b0;
            opnd_a        <= '0;
            opnd_b        <= '0;
            rf_mem_en     <= 1'b0;
            rf_read_addr1 <= '0;
            rf_read_addr2 <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue_accept) begin
                        rf_read_addr1 <= issue_rs1;
                        rf_read_addr2 <= issue_rs2;
                        rf_mem_en     <= 1'b1;
                        state_reg     <= READ;
                    end
                end
                READ: begin
                    opnd_a     <= capture_val[0];
                    opnd_b     <= capture_val[1];
                    opnd_valid <= 1'b1;
                    rf_mem_en  <= 1'b0;
                    state_reg  <= HOLD;
                end
                HOLD: begin
                    if (opnd_ready) begin
                        opnd_valid <= 1'b0;
                        if (issue_valid) begin
                            rf_read_addr1 <= issue_rs1;
                            rf_read_addr2 <= issue_rs2;
                            rf_mem_en     <= 1'b1;
                            state_reg     <= READ;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    opnd_valid <= 1'b0;
                    rf_mem_en  <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Writeback: always ready outside reset, so every wb_valid is an accept.
    // Address/data hold their last value when no pulse is active.
    // -----------------------------------------------------------------------
    assign wb_ready = ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_writ_en   <= 1'b0;
            rf_writ_addr <= '0;
            rf_writ_data <= '0;
        end else begin
            rf_writ_en <= wb_valid;
            if (wb_valid) begin
                rf_writ_addr <= wb_addr;
                rf_writ_data <= wb_data;
            end
        end
    end

    assign busy = (state_reg != IDLE) || rf_writ_en;

endmodule
